// File: rtl/polar_inst_seq_pkg.sv
// rtl/polar_inst_seq_pkg.sv - opcodes, instruction fields and FSM states for the polar instruction sequencer
package polar_inst_seq_pkg;

  localparam int OPC_HI = 11;
  localparam int OPC_LO = 9;
  localparam int ARG_HI = 8;
  localparam int ARG_LO = 0;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_F     = 3'd1,
    OP_G     = 3'd2,
    OP_PSUM  = 3'd3,
    OP_LEAF  = 3'd4,
    OP_BCAST = 3'd5,
    OP_RSVD  = 3'd6,
    OP_END   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_ADVANCE = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  // Reserved opcode 6 behaves like NOP, so only F..BCAST reach the datapath.
  function automatic logic is_issued(input op_e op);
    return (op == OP_F) || (op == OP_G) || (op == OP_PSUM) ||
           (op == OP_LEAF) || (op == OP_BCAST);
  endfunction

endpackage

// File: rtl/polar_inst_seq.sv
// rtl/polar_inst_seq.sv - fetch/issue/wait sequencer driving the polar decode datapath
module polar_inst_seq
  import polar_inst_seq_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                INST_W       = 12,
  parameter int                CNT_INST_MAX = 256,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_en,
  input  logic [INST_W-1:0] inst,
  output logic              exec_valid,
  output logic [2:0]        exec_op,
  output logic [8:0]        exec_arg,
  input  logic              exec_ready,
  input  logic              exec_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] inst_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(CNT_INST_MAX - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_err;
  op_e               w_op;

  assign w_op = op_e'(r_ir[OPC_HI:OPC_LO]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_END)        w_state_nxt = S_DONE;
        else if (is_issued(w_op))  w_state_nxt = S_ISSUE;
        else                       w_state_nxt = S_ADVANCE;
      end
      S_ISSUE:   if (exec_ready) w_state_nxt = S_WAIT;
      S_WAIT:    if (exec_done) w_state_nxt = S_ADVANCE;
      S_ADVANCE: w_state_nxt = (r_pc == LAST_PC) ? S_IDLE : S_FETCH;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_comb begin
    inst_en    = 1'b0;
    exec_valid = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:  busy       = 1'b0;
      S_FETCH: inst_en    = 1'b1;
      S_ISSUE: exec_valid = 1'b1;
      S_DONE:  done       = 1'b1;
      default: busy       = 1'b1;
    endcase
  end

  // Abort freezes PC, err and the issue count so software can inspect where the run stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= START_ADDR;
      r_ir  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc  <= START_ADDR;
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        S_FETCH: r_ir <= inst;
        S_ISSUE: begin
          if (exec_ready && (r_cnt != '1)) r_cnt <= r_cnt + ADDR_W'(1);
        end
        S_ADVANCE: begin
          if (r_pc == LAST_PC) r_err <= 1'b1;
          else                 r_pc  <= r_pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign inst_addr = r_pc;
  assign exec_op   = r_ir[OPC_HI:OPC_LO];
  assign exec_arg  = r_ir[ARG_HI:ARG_LO];
  assign err       = r_err;
  assign inst_cnt  = r_cnt;

endmodule

// File: tb/tb_polar_inst_seq.sv
// tb/tb_polar_inst_seq.sv - randomized trace-model bench for polar_inst_seq
module tb_polar_inst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       exec_ready = 1'b0;
  logic       exec_done = 1'b0;
  logic [7:0] inst_addr;
  logic       inst_en;
  logic [11:0] inst;
  logic       exec_valid;
  logic [2:0] exec_op;
  logic [8:0] exec_arg;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] inst_cnt;

  logic [11:0] mem [256];

  int n_cmp = 0;
  int n_fail = 0;

  polar_inst_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .inst_addr  (inst_addr),
    .inst_en    (inst_en),
    .inst       (inst),
    .exec_valid (exec_valid),
    .exec_op    (exec_op),
    .exec_arg   (exec_arg),
    .exec_ready (exec_ready),
    .exec_done  (exec_done),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .inst_cnt   (inst_cnt)
  );

  always #5 clk = ~clk;

  assign inst = mem[inst_addr];

  // One entry per clock: inputs to apply and outputs expected in that cycle.
  typedef struct {
    logic       st, ab, rd, dn;
    logic       en, vl, bz, dno, er;
    logic [7:0] a, c;
    logic [2:0] op;
    logic [8:0] arg;
  } ent_t;

  ent_t       tq[$];
  logic [7:0] m_pc = 8'd0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_err = 1'b0;
  bit         g_rnd = 1'b0;
  int         k;
  int         first_valid_k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic sp();
    return g_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void emit(input logic st, input logic ab, input logic rd, input logic dn,
                               input logic en, input logic vl, input logic bz, input logic dno,
                               input logic [2:0] op, input logic [8:0] arg);
    ent_t e;
    e.st = st; e.ab = ab; e.rd = rd; e.dn = dn;
    e.en = en; e.vl = vl; e.bz = bz; e.dno = dno;
    e.op = op; e.arg = arg;
    e.a = m_pc; e.c = m_cnt; e.er = m_err;
    tq.push_back(e);
    if (vl && first_valid_k < 0) first_valid_k = k;
    k++;
  endfunction

  function automatic void emit_idle(input logic st, input logic ab, input logic dn);
    emit(st, ab, sp(), dn, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endfunction

  // Expand one program run into its per-cycle trace using the documented latencies.
  function automatic void gen_run(input int abort_issue, input bit stop_at_issue, input int fixed_r);
    logic [2:0] op;
    logic [8:0] arg;
    int         r, d, issue_idx;
    logic       ab;
    k = 0;
    first_valid_k = -1;
    emit(1'b1, 1'b0, sp(), sp(), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    m_pc = 8'd0; m_cnt = 8'd0; m_err = 1'b0;
    issue_idx = 0;
    forever begin
      emit(sp(), 1'b0, sp(), sp(), 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
      op  = mem[m_pc][11:9];
      arg = mem[m_pc][8:0];
      emit(sp(), 1'b0, sp(), sp(), 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      if (op == 3'd7) begin
        emit(sp(), 1'b0, sp(), sp(), 1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        return;
      end
      if (op != 3'd0 && op != 3'd6) begin
        r = (fixed_r >= 0) ? fixed_r : (g_rnd ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < r; i++) begin
          emit(sp(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, op, arg);
          if (stop_at_issue) return;
        end
        emit(sp(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, op, arg);
        m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
        d = g_rnd ? int'($urandom_range(1, 4)) : 2;
        for (int j = 0; j < d; j++) begin
          ab = (issue_idx == abort_issue) && (j == 0);
          emit(sp(), ab, sp(), (j == d - 1) && !ab, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
          if (ab) return;
        end
        issue_idx++;
      end
      emit(sp(), 1'b0, sp(), sp(), 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      if (m_pc == 8'hFF) begin
        m_err = 1'b1;
        return;
      end
      m_pc = m_pc + 8'd1;
    end
  endfunction

  task automatic run_queue();
    ent_t e;
    while (tq.size() > 0) begin
      @(negedge clk);
      e = tq.pop_front();
      chk("inst_en",    32'(inst_en),    32'(e.en));
      chk("inst_addr",  32'(inst_addr),  32'(e.a));
      chk("exec_valid", 32'(exec_valid), 32'(e.vl));
      chk("busy",       32'(busy),       32'(e.bz));
      chk("done",       32'(done),       32'(e.dno));
      chk("err",        32'(err),        32'(e.er));
      chk("inst_cnt",   32'(inst_cnt),   32'(e.c));
      if (e.vl) begin
        chk("exec_op",  32'(exec_op),  32'(e.op));
        chk("exec_arg", 32'(exec_arg), 32'(e.arg));
      end
      start = e.st; abort = e.ab; exec_ready = e.rd; exec_done = e.dn;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; exec_ready = 1'b0; exec_done = 1'b0;
  endtask

  task automatic fill_random(input int max_op);
    for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, max_op)), 9'($urandom)};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(inst_addr),  32'd0);
    chk({tag, "_en"},    32'(inst_en),    32'd0);
    chk({tag, "_valid"}, 32'(exec_valid), 32'd0);
    chk({tag, "_op"},    32'(exec_op),    32'd0);
    chk({tag, "_arg"},   32'(exec_arg),   32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
    chk({tag, "_cnt"},   32'(inst_cnt),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_random(6);
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two issues, ready tied high, done two cycles after accept.
    g_rnd = 1'b0;
    fill_random(6);
    mem[0] = 12'h201; mem[1] = 12'h402; mem[2] = 12'hE00;
    gen_run(-1, 1'b0, -1);
    chk("t1_model_first_valid", 32'(first_valid_k), 32'd3);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t1_cnt", 32'(inst_cnt), 32'd2);
    chk("t1_err", 32'(err), 32'd0);

    // Back-pressure: ready low for five ISSUE cycles.
    mem[0] = 12'h655; mem[1] = 12'hE00;
    gen_run(-1, 1'b0, 5);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t2_cnt", 32'(inst_cnt), 32'd1);

    // NOPs cost three cycles each.
    mem[0] = 12'h000; mem[1] = 12'h000; mem[2] = 12'h8FF; mem[3] = 12'hE00;
    gen_run(-1, 1'b0, -1);
    chk("t3_model_first_valid", 32'(first_valid_k), 32'd9);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t3_addr", 32'(inst_addr), 32'd3);

    // Runaway: no END anywhere.
    g_rnd = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = {3'd1, 9'($urandom)};
    gen_run(-1, 1'b0, -1);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_cnt", 32'(inst_cnt), 32'd255);
    chk("t4_addr", 32'(inst_addr), 32'd255);
    chk("t4_busy", 32'(busy), 32'd0);

    // Abort during the second WAIT; late done and abort+start are both ignored.
    mem[0] = 12'h201; mem[1] = 12'h402; mem[2] = 12'h603; mem[3] = 12'hE00;
    gen_run(1, 1'b0, -1);
    emit_idle(1'b0, 1'b0, 1'b1);
    emit_idle(1'b0, 1'b0, 1'b1);
    emit_idle(1'b1, 1'b1, 1'b0);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t5_cnt", 32'(inst_cnt), 32'd2);
    chk("t5_addr", 32'(inst_addr), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
    gen_run(-1, 1'b0, -1);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t5_rerun_cnt", 32'(inst_cnt), 32'd3);

    // Random programs including the reserved opcode.
    for (int n = 0; n < 8; n++) begin
      fill_random(6);
      mem[$urandom_range(2, 30)] = {3'd7, 9'($urandom)};
      gen_run(-1, 1'b0, -1);
      emit_idle(1'b0, 1'b0, 1'b0);
      run_queue();
    end

    // Asynchronous reset while in ISSUE.
    mem[0] = 12'h000; mem[1] = 12'h000; mem[2] = 12'h3AB; mem[3] = 12'hE00;
    gen_run(-1, 1'b1, 3);
    run_queue();
    chk("t6_in_issue", 32'(exec_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("t6");
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'd0; m_cnt = 8'd0; m_err = 1'b0;
    emit_idle(1'b0, 1'b0, 1'b0);
    gen_run(-1, 1'b0, -1);
    emit_idle(1'b0, 1'b0, 1'b0);
    run_queue();
    chk("t6_rerun_cnt", 32'(inst_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
